// File: rtl/uart_frame_pkg.sv
// Shared constants, frame FSM state encoding and baud-rate helper for the uart_frame_tx block.
// The UART_TX_PARITY_EN build option is handled in uart_byte_tx; nothing here depends on it.
package uart_frame_pkg;

  localparam logic [7:0] FRAME_HDR0 = 8'h55;
  localparam logic [7:0] FRAME_HDR1 = 8'hAA;

  // The state names the byte currently on the line; IDLE and DONE have nothing on it.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR0,
    ST_HDR1,
    ST_FUNC,
    ST_LEN,
    ST_PAYLOAD,
    ST_CSUM,
    ST_DONE
  } frame_state_t;

  // Clock cycles per serial bit, truncated toward zero.
  function automatic int bit_cycles(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// Bit-level serializer: start bit, 8 data bits LSB first, optional even parity, stop bit.
// Define UART_TX_PARITY_EN for 8E1 (11 bits/byte); the default build is 8N1 (10 bits/byte).
module uart_byte_tx #(
  parameter int BIT_CYCLES = 434
) (
  input  logic       clk_50M,
  input  logic       rst,
  input  logic [7:0] byte_data,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       uart_txd
);
  import uart_frame_pkg::*;

`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  // Everything after the start bit waits in the shift register.
  localparam int SHIFT_W = FRAME_BITS - 1;
  localparam int CNT_W   = $clog2(BIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYCLES - 1);

  logic [CNT_W-1:0]   bit_cnt;
  logic [3:0]         bits_left;
  logic [SHIFT_W-1:0] shreg;
  logic [SHIFT_W-1:0] load_word;
  logic               active;
  logic               txd_q;
  logic               accept;

`ifdef UART_TX_PARITY_EN
  assign load_word = {1'b1, ^byte_data, byte_data};
`else
  assign load_word = {1'b1, byte_data};
`endif

  // Ready during the final cycle of the stop bit, so the next start bit follows with no gap.
  assign byte_ready = !active || (bit_cnt == CNT_LAST && bits_left == 4'd0);
  assign accept     = byte_valid && byte_ready;
  assign uart_txd   = txd_q;

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // in this block samples the values from before the edge.
  always_ff @(posedge clk_50M) begin
    if (rst) begin
      active    <= 1'b0;
      txd_q     <= 1'b1;
      bit_cnt   <= '0;
      bits_left <= 4'd0;
      shreg     <= '0;
    end else if (accept) begin
      active    <= 1'b1;
      txd_q     <= 1'b0;
      bit_cnt   <= '0;
      bits_left <= 4'(SHIFT_W);
      shreg     <= load_word;
    end else if (active) begin
      if (bit_cnt == CNT_LAST) begin
        bit_cnt <= '0;
        if (bits_left == 4'd0) begin
          active <= 1'b0;
          txd_q  <= 1'b1;
        end else begin
          txd_q     <= shreg[0];
          shreg     <= shreg >> 1;
          bits_left <= bits_left - 4'd1;
        end
      end else begin
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_frame_tx.sv
// FPGA->host framer: 0x55, 0xAA, func, len, payload[0..len-1], checksum, serialized on uart_txd.
// Build option UART_TX_PARITY_EN (in uart_byte_tx) switches the line format from 8N1 to 8E1.
module uart_frame_tx #(
  parameter int _CLK_FREQ    = 50_000_000,
  parameter int _BAUD        = 115200,
  parameter int _MAX_PAYLOAD = 11
) (
  input  logic                      clk_50M,
  input  logic                      rst,
  input  logic                      send_req,
  input  logic [7:0]                func_code,
  input  logic [3:0]                payload_len,
  input  logic [8*_MAX_PAYLOAD-1:0] payload,
  output logic                      busy,
  output logic                      frame_done,
  output logic                      uart_txd
);
  import uart_frame_pkg::*;

  localparam int         BIT_CYCLES = bit_cycles(_CLK_FREQ, _BAUD);
  localparam logic [3:0] MAX_LEN    = 4'(_MAX_PAYLOAD);

  frame_state_t              state;
  logic [7:0]                func_q;
  logic [3:0]                len_q;
  logic [8*_MAX_PAYLOAD-1:0] payload_q;
  logic [3:0]                idx;
  logic [7:0]                csum_q;
  logic                      busy_q;
  logic                      done_q;

  logic [3:0] len_clamped;
  logic [3:0] sel;
  logic [7:0] pbyte;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       byte_ready;
  logic       handoff;
  logic       more_payload;

  assign len_clamped  = (payload_len > MAX_LEN) ? MAX_LEN : payload_len;
  assign more_payload = (idx + 4'd1) < len_q;
  assign handoff      = byte_valid && byte_ready;
  assign busy         = busy_q;
  assign frame_done   = done_q;

  // Payload byte offered next: byte 0 after LEN, otherwise the one after the current index.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    sel   = (state == ST_LEN) ? 4'd0 : idx + 4'd1;
    pbyte = 8'h00;
    for (int k = 0; k < _MAX_PAYLOAD; k++) begin
      if (sel == 4'(k)) pbyte = payload_q[8*k +: 8];
    end
  end

  // While one byte is on the line the serializer is offered the next one.
  always_comb begin
    byte_valid = 1'b0;
    byte_data  = FRAME_HDR0;
    unique case (state)
      ST_IDLE, ST_DONE: begin
        byte_valid = send_req;
        byte_data  = FRAME_HDR0;
      end
      ST_HDR0: begin
        byte_valid = 1'b1;
        byte_data  = FRAME_HDR1;
      end
      ST_HDR1: begin
        byte_valid = 1'b1;
        byte_data  = func_q;
      end
      ST_FUNC: begin
        byte_valid = 1'b1;
        byte_data  = {4'd0, len_q};
      end
      ST_LEN: begin
        byte_valid = 1'b1;
        byte_data  = (len_q == 4'd0) ? csum_q : pbyte;
      end
      ST_PAYLOAD: begin
        byte_valid = 1'b1;
        byte_data  = more_payload ? pbyte : csum_q;
      end
      ST_CSUM: begin
        byte_valid = 1'b0;
        byte_data  = csum_q;
      end
      default: begin
        byte_valid = 1'b0;
        byte_data  = FRAME_HDR0;
      end
    endcase
  end

  always_ff @(posedge clk_50M) begin
    if (rst) begin
      state     <= ST_IDLE;
      func_q    <= 8'h00;
      len_q     <= 4'd0;
      payload_q <= '0;
      idx       <= 4'd0;
      csum_q    <= 8'h00;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        ST_IDLE, ST_DONE: begin
          if (send_req) begin
            func_q    <= func_code;
            len_q     <= len_clamped;
            payload_q <= payload;
            idx       <= 4'd0;
            csum_q    <= func_code + {4'd0, len_clamped};
            busy_q    <= 1'b1;
            state     <= ST_HDR0;
          end else begin
            busy_q <= 1'b0;
            state  <= ST_IDLE;
          end
        end
        ST_HDR0: if (handoff) state <= ST_HDR1;
        ST_HDR1: if (handoff) state <= ST_FUNC;
        ST_FUNC: if (handoff) state <= ST_LEN;
        ST_LEN: begin
          if (handoff) begin
            if (len_q == 4'd0) begin
              state <= ST_CSUM;
            end else begin
              idx    <= 4'd0;
              csum_q <= csum_q + pbyte;
              state  <= ST_PAYLOAD;
            end
          end
        end
        ST_PAYLOAD: begin
          if (handoff) begin
            if (more_payload) begin
              idx    <= idx + 4'd1;
              csum_q <= csum_q + pbyte;
            end else begin
              state <= ST_CSUM;
            end
          end
        end
        // byte_ready here marks the last cycle of the checksum's stop bit.
        ST_CSUM: begin
          if (byte_ready) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  uart_byte_tx #(
    .BIT_CYCLES (BIT_CYCLES)
  ) u_byte_tx (
    .clk_50M    (clk_50M),
    .rst        (rst),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .uart_txd   (uart_txd)
  );

endmodule
